keypad_debouncer: RTL and testbench

KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

---
 rtl/keypad_debouncer.sv | 157 +++++++++++++++
 tb/tb_keypad_debouncer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer.sv
// Keypad row debouncer for a column-scanned 4x4 matrix.
// Latches one (row, col) hit while the upstream column shifter is frozen, demands
// DEBOUNCE_CYCLES stable samples for both press and release, and emits a one-cycle
// key_valid pulse together with the hex code of the accepted key.
module keypad_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_onehot,
  input  logic [3:0] rows_n,
  output logic       scan_hold,
  output logic [3:0] key_code,
  output logic       key_valid
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StHeld,
    StDebRelease
  } state_e;

  state_e            state_q;
  logic [3:0]        rows_meta_q;
  logic [3:0]        rows_sync_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        row_q;
  logic [1:0]        col_q;

  logic              row_single;
  logic [1:0]        row_idx;
  logic              col_single;
  logic [1:0]        col_idx;
  logic              row_low;

  // Hex code for a (row, col) position on the keypad.
  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; reset parks it at "no key" so no stale press survives reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      rows_meta_q <= rows_n;
      rows_sync_q <= rows_meta_q;
    end
  end

  // Decode exactly-one-low rows and exactly-one-high column; anything else is ignored.
  always_comb begin
    row_single = 1'b1;
    row_idx    = 2'd0;
    case (rows_sync_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_single = 1'b0;
    endcase
    col_single = 1'b1;
    col_idx    = 2'd0;
    case (col_onehot)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_single = 1'b0;
    endcase
    row_low = ~rows_sync_q[row_q];
  end

  // Debounce FSM; scan_hold and key_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StScan;
      cnt_q     <= '0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      scan_hold <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state_q)
        StScan: begin
          if (row_single && col_single) begin
            row_q     <= row_idx;
            col_q     <= col_idx;
            cnt_q     <= '0;
            state_q   <= StDebPress;
            scan_hold <= 1'b1;
          end
        end
        StDebPress: begin
          if (!row_low) begin
            state_q   <= StScan;
            scan_hold <= 1'b0;
          end else if (cnt_q == CntLast) begin
            key_code  <= code_of(row_q, col_q);
            key_valid <= 1'b1;
            state_q   <= StHeld;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (!row_low) begin
            cnt_q   <= '0;
            state_q <= StDebRelease;
          end
        end
        StDebRelease: begin
          if (row_low) begin
            state_q <= StHeld;
          end else if (cnt_q == CntLast) begin
            state_q   <= StScan;
            scan_hold <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q   <= StScan;
          scan_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer: directed scenarios plus random key activity, every cycle
// compared against a run-length reference model of the debounce rules.
module tb_keypad_debouncer;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_onehot;
  logic [3:0] rows_n;
  logic       scan_hold;
  logic [3:0] key_code;
  logic       key_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  keypad_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .col_onehot (col_onehot),
    .rows_n     (rows_n),
    .scan_hold  (scan_hold),
    .key_code   (key_code),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a two-deep delay line for the synchronizer, then run lengths of
  // the latched row's level counted against DC.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] hist [$];
  bit         m_busy, m_accepted, m_releasing, m_valid;
  int         m_run, m_r, m_c;
  logic [3:0] m_code;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] rows, input logic [3:0] col, input logic rst);
    logic [3:0] s;
    bit         low;
    if (!rst) begin
      m_busy = 0;
      m_valid = 0;
      m_code = 4'h0;
      hist = '{4'hF, 4'hF};
      return;
    end
    s = hist[0];
    void'(hist.pop_front());
    hist.push_back(rows);
    m_valid = 0;
    if (!m_busy) begin
      if ($countones(~s) == 1 && $countones(col) == 1) begin
        m_busy = 1;
        m_accepted = 0;
        m_run = 0;
        for (int i = 0; i < 4; i++) begin
          if (!s[i]) m_r = i;
          if (col[i]) m_c = i;
        end
      end
    end else begin
      low = !s[m_r];
      if (!m_accepted) begin
        if (!low) m_busy = 0;
        else begin
          m_run++;
          if (m_run == DC) begin
            m_accepted = 1;
            m_releasing = 0;
            m_valid = 1;
            m_code = kmap[m_r * 4 + m_c];
          end
        end
      end else if (!m_releasing) begin
        if (!low) begin
          m_releasing = 1;
          m_run = 0;
        end
      end else begin
        if (low) m_releasing = 0;
        else begin
          m_run++;
          if (m_run == DC) m_busy = 0;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare outputs.
  task automatic step(input logic [3:0] rows, input logic [3:0] col, input logic rst);
    rows_n = rows;
    col_onehot = col;
    reset = rst;
    @(posedge clk);
    model_step(rows, col, rst);
    #1;
    if (key_valid === 1'b1) pulses++;
    check_eq("key_valid", 32'(key_valid), 32'(m_valid));
    check_eq("key_code", 32'(key_code), 32'(m_code));
    check_eq("scan_hold", 32'(scan_hold), 32'(m_busy));
  endtask

  task automatic steps(input int n, input logic [3:0] rows, input logic [3:0] col);
    for (int i = 0; i < n; i++) step(rows, col, 1'b1);
  endtask

  int first_hold, valid_edge;

  initial begin
    rows_n = 4'hF;
    col_onehot = 4'b0000;
    reset = 1'b0;
    hist = '{4'hF, 4'hF};
    step(4'hF, 4'b0000, 1'b0);
    step(4'hF, 4'b0000, 1'b0);
    check_eq("reset_code", 32'(key_code), 32'h0);
    check_eq("reset_hold", 32'(scan_hold), 32'h0);
    check_eq("reset_valid", 32'(key_valid), 32'h0);

    // Press '5' and check the exact latency.
    pulses = 0;
    first_hold = 0;
    valid_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      step(4'b1101, 4'b0010, 1'b1);
      if (scan_hold && first_hold == 0) first_hold = i;
      if (key_valid) valid_edge = i;
    end
    check_eq("p5_hold_edge", 32'(first_hold), 32'd3);
    check_eq("p5_valid_edge", 32'(valid_edge), 32'(DC + 3));
    check_eq("p5_pulses", 32'(pulses), 32'd1);
    check_eq("p5_code", 32'(key_code), 32'h5);
    steps(10, 4'hF, 4'b0010);
    check_eq("p5_released", 32'(scan_hold), 32'h0);

    // Press bounce.
    pulses = 0;
    steps(3, 4'b1101, 4'b0010);
    steps(6, 4'hF, 4'b0010);
    check_eq("bounce_pulses", 32'(pulses), 32'd0);
    check_eq("bounce_code", 32'(key_code), 32'h5);
    check_eq("bounce_hold", 32'(scan_hold), 32'h0);

    // Held key plus a second row, then key '0'.
    pulses = 0;
    steps(10, 4'b1101, 4'b0010);
    steps(6, 4'b0101, 4'b0010);
    check_eq("two_row_pulses", 32'(pulses), 32'd1);
    steps(10, 4'hF, 4'b0010);
    pulses = 0;
    steps(12, 4'b0111, 4'b0010);
    check_eq("key0_pulses", 32'(pulses), 32'd1);
    check_eq("key0_code", 32'(key_code), 32'h0);
    steps(10, 4'hF, 4'b0000);

    // Release bounce.
    steps(10, 4'b1101, 4'b0010);
    pulses = 0;
    steps(2, 4'hF, 4'b0010);
    steps(6, 4'b1101, 4'b0010);
    check_eq("rel_bounce_pulses", 32'(pulses), 32'd0);
    check_eq("rel_bounce_hold", 32'(scan_hold), 32'h1);
    steps(10, 4'hF, 4'b0000);

    // Multi-row and invalid column.
    pulses = 0;
    steps(8, 4'b1100, 4'b0010);
    steps(8, 4'b1101, 4'b0110);
    check_eq("invalid_hold", 32'(scan_hold), 32'h0);
    check_eq("invalid_pulses", 32'(pulses), 32'd0);
    steps(4, 4'hF, 4'b0000);

    // Reset while held.
    steps(10, 4'b1101, 4'b0010);
    step(4'b1101, 4'b0010, 1'b0);
    check_eq("rst_held_code", 32'(key_code), 32'h0);
    check_eq("rst_held_valid", 32'(key_valid), 32'h0);
    check_eq("rst_held_hold", 32'(scan_hold), 32'h0);
    steps(12, 4'hF, 4'b0000);

    // Random activity, checked every cycle against the model.
    for (int seg = 0; seg < 300; seg++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if (kind == 0) begin
        step(4'($urandom), 4'($urandom), 1'b0);
      end else if (kind <= 6) begin
        logic [3:0] row_pat;
        logic [3:0] col_pat;
        row_pat = 4'hF ^ 4'(1 << $urandom_range(0, 3));
        col_pat = 4'(1 << $urandom_range(0, 3));
        for (int i = 0; i < len; i++) begin
          logic [3:0] cp;
          cp = ($urandom_range(0, 7) == 0) ? 4'($urandom) : col_pat;
          if ($urandom_range(0, 5) == 0) step(4'hF, cp, 1'b1);
          else step(row_pat, cp, 1'b1);
        end
      end else if (kind == 7) begin
        steps(len, 4'($urandom) & 4'b1100, 4'(1 << $urandom_range(0, 3)));
      end else if (kind == 8) begin
        steps(len, 4'hF, 4'($urandom));
      end else begin
        for (int i = 0; i < (len % 5) + 1; i++) step(4'($urandom), 4'($urandom), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
